// File: rtl/lfsr_init_arbiter.sv
// lfsr_init_arbiter: round-robin arbiter that time-shares one code-phase to
// G1/G2 LFSR-state converter among NUM_CH channels.
//
// Handshake: a channel raises req[i] with req_phase[i] stable and holds it
// until it samples ack[i] (a one-cycle, one-hot strobe). rsp_g1/rsp_g2/
// rsp_err/rsp_ch are valid in the ack cycle and hold until the next ack.
//
// Optional feature: define LFSR_ARB_CACHE_EN to add a one-entry cache of the
// last converted phase. A repeated phase then skips the converter wait.
module lfsr_init_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int LATENCY = 2,
  parameter int PHASE_W = 10,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          req,
  input  logic [NUM_CH*PHASE_W-1:0]  req_phase,
  output logic [NUM_CH-1:0]          ack,
  output logic [9:0]                 rsp_g1,
  output logic [9:0]                 rsp_g2,
  output logic                       rsp_err,
  output logic [CH_W-1:0]            rsp_ch,
  output logic                       busy,
  output logic [PHASE_W-1:0]         conv_phase,
  input  logic [9:0]                 conv_g1,
  input  logic [9:0]                 conv_g2,
  output logic [1:0]                 dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [CH_W-1:0]      ptr_q;
  logic [CH_W-1:0]      gnt_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [NUM_CH-1:0]    ack_q;
  logic [9:0]           rsp_g1_q;
  logic [9:0]           rsp_g2_q;
  logic                 rsp_err_q;
  logic [CH_W-1:0]      rsp_ch_q;
  logic [PHASE_W-1:0]   conv_phase_q;

  logic                 hit;
  logic [CH_W-1:0]      sel;
  logic [CH_W-1:0]      cand;
  logic [PHASE_W-1:0]   sel_phase;
  logic                 sel_err;
  int                   idx;

  // Round-robin search: first requester after ptr_q, ascending with wrap.
  always_comb begin
    hit  = 1'b0;
    sel  = '0;
    cand = '0;
    idx  = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      cand = CH_W'(idx);
      if (!hit && req[cand]) begin
        hit = 1'b1;
        sel = cand;
      end
    end
  end

  assign sel_phase = req_phase[sel*PHASE_W +: PHASE_W];
  assign sel_err   = (32'(sel_phase) > 32'd1022);

`ifdef LFSR_ARB_CACHE_EN
  logic               cache_vld_q;
  logic [PHASE_W-1:0] cache_phase_q;
  logic [9:0]         cache_g1_q;
  logic [9:0]         cache_g2_q;
  logic               cache_hit;

  assign cache_hit = cache_vld_q && (cache_phase_q == sel_phase);

  // Cache refresh on every completed converter wait.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_vld_q   <= 1'b0;
      cache_phase_q <= '0;
      cache_g1_q    <= '0;
      cache_g2_q    <= '0;
    end else if (state_q == WAIT && cnt_q == '0) begin
      cache_vld_q   <= 1'b1;
      cache_phase_q <= conv_phase_q;
      cache_g1_q    <= conv_g1;
      cache_g2_q    <= conv_g2;
    end
  end
`endif

  // Arbiter FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      ptr_q        <= CH_W'(NUM_CH - 1);
      gnt_q        <= '0;
      cnt_q        <= '0;
      ack_q        <= '0;
      rsp_g1_q     <= '0;
      rsp_g2_q     <= '0;
      rsp_err_q    <= 1'b0;
      rsp_ch_q     <= '0;
      conv_phase_q <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (hit) begin
            gnt_q <= sel;
            ptr_q <= sel;
            if (sel_err) begin
              // Out-of-range phase: answer at once, converter untouched.
              rsp_err_q <= 1'b1;
              rsp_g1_q  <= 10'h3FF;
              rsp_g2_q  <= 10'h3FF;
              rsp_ch_q  <= sel;
              ack_q     <= NUM_CH'(1) << sel;
              state_q   <= DONE;
            end
`ifdef LFSR_ARB_CACHE_EN
            else if (cache_hit) begin
              rsp_err_q <= 1'b0;
              rsp_g1_q  <= cache_g1_q;
              rsp_g2_q  <= cache_g2_q;
              rsp_ch_q  <= sel;
              ack_q     <= NUM_CH'(1) << sel;
              state_q   <= DONE;
            end
`endif
            else begin
              conv_phase_q <= sel_phase;
              cnt_q        <= CNT_W'(LATENCY - 1);
              state_q      <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            rsp_g1_q  <= conv_g1;
            rsp_g2_q  <= conv_g2;
            rsp_err_q <= 1'b0;
            rsp_ch_q  <= gnt_q;
            ack_q     <= NUM_CH'(1) << gnt_q;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack        = ack_q;
  assign rsp_g1     = rsp_g1_q;
  assign rsp_g2     = rsp_g2_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_ch     = rsp_ch_q;
  assign conv_phase = conv_phase_q;
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_lfsr_init_arbiter.sv
// Testbench for lfsr_init_arbiter with a behavioural shared converter.
module tb_lfsr_init_arbiter;

  localparam int NUM_CH  = 4;
  localparam int LATENCY = 2;
  localparam int PHASE_W = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NUM_CH-1:0]         req = '0;
  logic [NUM_CH*PHASE_W-1:0] req_phase = '0;
  logic [NUM_CH-1:0]         ack;
  logic [9:0]                rsp_g1, rsp_g2;
  logic                      rsp_err;
  logic [1:0]                rsp_ch;
  logic                      busy;
  logic [PHASE_W-1:0]        conv_phase;
  logic [9:0]                conv_g1, conv_g2;
  logic [1:0]                dbg_state;

  lfsr_init_arbiter #(.NUM_CH(NUM_CH), .LATENCY(LATENCY), .PHASE_W(PHASE_W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_phase(req_phase), .ack(ack),
    .rsp_g1(rsp_g1), .rsp_g2(rsp_g2), .rsp_err(rsp_err), .rsp_ch(rsp_ch),
    .busy(busy), .conv_phase(conv_phase), .conv_g1(conv_g1), .conv_g2(conv_g2),
    .dbg_state(dbg_state)
  );

  // ---------------- converter model ----------------
  // G1 = 1+x^3+x^10, G2 = 1+x^2+x^3+x^6+x^8+x^9+x^10, both seeded all-ones and
  // advanced phase chips. One register stage gives valid output LATENCY=2
  // cycles after conv_phase changes.
  function automatic logic [19:0] conv_model(input logic [9:0] p);
    logic [9:0] g1;
    logic [9:0] g2;
    g1 = 10'h3FF;
    g2 = 10'h3FF;
    for (int k = 0; k < int'(p); k++) begin
      g1 = {g1[8:0], g1[9] ^ g1[2]};
      g2 = {g2[8:0], g2[9] ^ g2[8] ^ g2[7] ^ g2[5] ^ g2[2] ^ g2[1]};
    end
    return {g1, g2};
  endfunction

  logic [19:0] conv_pipe = '0;
  always @(posedge clk) conv_pipe <= conv_model(conv_phase);
  assign conv_g1 = conv_pipe[19:10];
  assign conv_g2 = conv_pipe[9:0];

  // ---------------- scoreboard ----------------
  // entry: {ack cycle[56:25], ch[24:21], err[20], g1[19:10], g2[9:0]}
  logic [56:0] exp_q[$];
  logic [56:0] mon_e;
  int st_total = 0, st_fail = 0;
  int m_total = 0, m_fail = 0;

`ifdef LFSR_ARB_CACHE_EN
  logic       m_cache_v = 1'b0;
  logic [9:0] m_cache_p = '0;
`endif

  task automatic st_check(input string name, input logic [31:0] act, input logic [31:0] exp);
    st_total++;
    if (act !== exp) begin
      st_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_check(input string name, input logic [31:0] act, input logic [31:0] exp);
    m_total++;
    if (act !== exp) begin
      m_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected response for a grant decided in IDLE cycle tg; returns ack cycle.
  task automatic predict(input int ch, input logic [9:0] ph, input int tg, output int ta);
    logic [19:0] g;
    logic        err;
    int          lat;
    err = (ph > 10'd1022);
    if (err) begin
      g   = 20'hFFFFF;
      lat = 1;
    end else begin
      g   = conv_model(ph);
      lat = LATENCY + 1;
`ifdef LFSR_ARB_CACHE_EN
      if (m_cache_v && m_cache_p == ph) lat = 1;
      else begin
        m_cache_v = 1'b1;
        m_cache_p = ph;
      end
`endif
    end
    ta = tg + lat;
    exp_q.push_back({32'(ta), 4'(ch), err, g});
  endtask

  // Monitor: compare every presented ack against the queue head.
  always @(negedge clk) begin
    if (ack != '0) begin
      mon_check("ack_onehot", 32'($onehot(ack)), 32'd1);
      if (exp_q.size() == 0) begin
        m_total++;
        m_fail++;
        $display("FAIL unexpected_ack: got ack=%0h expected none (cyc %0d)", ack, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_check("ack_vec", 32'(ack), 32'd1 << mon_e[24:21]);
        mon_check("rsp_ch", 32'(rsp_ch), 32'(mon_e[24:21]));
        mon_check("rsp_err", 32'(rsp_err), 32'(mon_e[20]));
        mon_check("rsp_g1", 32'(rsp_g1), 32'(mon_e[19:10]));
        mon_check("rsp_g2", 32'(rsp_g2), 32'(mon_e[9:0]));
        mon_check("ack_cycle", 32'(cyc), mon_e[56:25]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Single request issued in an IDLE cycle; dropped on the edge that samples ack.
  task automatic req_one(input int ch, input logic [9:0] ph);
    int  t0, ta;
    bit  got;
    req_phase[ch*PHASE_W +: PHASE_W] = ph;
    req[ch] = 1'b1;
    t0 = cyc;
    predict(ch, ph, t0, ta);
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if ((ta - t0) == LATENCY + 1 && cyc > t0 && cyc < ta) begin
        st_check("conv_phase_wait", 32'(conv_phase), 32'(ph));
        st_check("busy_wait", 32'(busy), 32'd1);
      end
      if (ack[ch]) got = 1'b1;
    end
    if (!got) st_check("ack_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req[ch] = 1'b0;
  endtask

  task automatic check_reset_values();
    st_check("rst_ack", 32'(ack), 32'd0);
    st_check("rst_g1", 32'(rsp_g1), 32'd0);
    st_check("rst_g2", 32'(rsp_g2), 32'd0);
    st_check("rst_err", 32'(rsp_err), 32'd0);
    st_check("rst_ch", 32'(rsp_ch), 32'd0);
    st_check("rst_busy", 32'(busy), 32'd0);
    st_check("rst_conv_phase", 32'(conv_phase), 32'd0);
    st_check("rst_state", 32'(dbg_state), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int t, ta, last;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single requests; ch0 first confirms pointer resets to NUM_CH-1.
    req_one(0, 10'd0);
    req_one(1, 10'd1022);
    req_one(2, 10'd1023);
    st_check("conv_phase_hold_err", 32'(conv_phase), 32'd1022);
    req_one(3, 10'd7);

    // All channels held: strict round robin, one ack per LATENCY+2 cycles.
    for (int i = 0; i < NUM_CH; i++) req_phase[i*PHASE_W +: PHASE_W] = 10'(10 * (i + 1));
    req = '1;
    t = cyc;
    ta = t;
    for (int k = 0; k < 6; k++) begin
      predict(k % NUM_CH, 10'(10 * ((k % NUM_CH) + 1)), t, ta);
      t = ta + 1;
    end
    last = ta;
    for (int n = 0; n < 60 && cyc < last; n++) begin
      @(posedge clk);
      #1;
    end
    req = '0;
    @(posedge clk);
    #1;

    // Reset in the middle of a ch3 conversion: dropped, no ack.
    req_phase[3*PHASE_W +: PHASE_W] = 10'd300;
    req[3] = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    st_check("busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b0;
    req[3] = 1'b0;
`ifdef LFSR_ARB_CACHE_EN
    m_cache_v = 1'b0;
`endif
    #1;
    check_reset_values();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    req_one(3, 10'd300);

    // Repeated phase, then a neighbouring one.
    req_one(0, 10'd500);
    req_one(0, 10'd500);
    req_one(0, 10'd501);

    repeat (6) @(posedge clk);
    #1;
    st_check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", (st_total + m_total) - (st_fail + m_fail), st_total + m_total);
    $finish;
  end

endmodule

// File: doc/lfsr_init_arbiter.md
Name: lfsr_init_arbiter

Overview:
- Shares one code-phase-to-LFSR converter (phase in, G1/G2 10-bit states out, fixed pipeline latency) among NUM_CH tracking/acquisition channels.
- Each channel requests an LFSR seed for a C/A code phase (0..1022).
- The arbiter grants requests round-robin, drives the converter's phase input, waits out the converter latency, and returns G1/G2 to the granted channel with a one-cycle ack.
- Sits between the channel bank and the single shared converter instance.

Parameters:
NUM_CH, 4, number of requesting channels (2..16)
LATENCY, 2, converter cycles from phase change to valid g1/g2 (>=1)
PHASE_W, 10, code phase width; valid phases 0..1022

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
req  in  NUM_CH  per-channel request, level, held until ack
req_phase  in  NUM_CH*PHASE_W  per-channel phase, channel i at [i*PHASE_W +: PHASE_W], stable while req[i]=1
ack  out  NUM_CH  one-hot one-cycle response strobe
rsp_g1  out  10  G1 state for acked channel
rsp_g2  out  10  G2 state for acked channel
rsp_err  out  1  phase out of range (>1022), valid with ack
rsp_ch  out  $clog2(NUM_CH)  index of acked channel, valid with ack
busy  out  1  high when state != IDLE
conv_phase  out  PHASE_W  registered phase to converter
conv_g1  in  10  converter G1 output
conv_g2  in  10  converter G2 output

Behaviour:
- Reset (rst=0, async) values: state IDLE, ack=0, rsp_g1=rsp_g2=0, rsp_err=0, rsp_ch=0, conv_phase=0, busy=0, rr pointer = NUM_CH-1 (ch0 highest priority first).
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - Search req starting at ptr+1 mod NUM_CH, ascending with wrap.
  - On first hit g, on the clock edge: latch g, ptr<=g.
  - Valid phase: conv_phase<=req_phase[g], cnt<=LATENCY-1, ->WAIT.
  - Phase >1022: leave conv_phase unchanged, rsp_err<=1, rsp_g1<=rsp_g2<=10'h3FF, ->DONE.
- WAIT:
  - cnt decrements each cycle.
  - At cnt==0: rsp_g1<=conv_g1, rsp_g2<=conv_g2, rsp_err<=0, ->DONE.
- DONE:
  - ack[g]=1 and rsp_ch=g for exactly this cycle, then ->IDLE.
  - rsp_* hold their values until the next DONE.
- Latency, valid phase: grant decided in IDLE cycle t -> ack in cycle t+LATENCY+1. Invalid phase: ack in cycle t+1.
- Throughput: one conversion per LATENCY+2 cycles. The next IDLE evaluation follows DONE.
- Handshake:
  - Requester drops req on the edge where it samples ack. req is therefore low in the IDLE cycle after DONE.
  - If req stays high, the channel is requested again. Round-robin still places it last.
  - req changes of a non-granted channel during WAIT/DONE are ignored until IDLE.
  - Deassertion of the granted channel's req mid-transaction does not abort; ack is still issued.
- Simultaneous requests: strictly round-robin; no channel waits more than NUM_CH-1 grants.
- Reset mid-operation: immediate return to reset values. In-flight transaction is dropped with no ack; requesters must re-request.
- conv_phase changes only on grant edges, so converter input is stable throughout WAIT.

Optional Feature:
- Macro: LFSR_ARB_CACHE_EN.
- Defined:
  - One-entry cache of last valid conversion: phase, g1, g2, valid flag. Valid flag is cleared on reset.
  - In IDLE, if the granted phase equals the cached phase and the cache is valid, skip WAIT. Go directly to DONE with cached g1/g2 (ack at t+1). conv_phase is not updated.
  - Every WAIT completion refreshes the cache.
- Not defined: every valid request goes through WAIT. No cache registers exist.

Test Plan:
- Reset then single req[0], phase 0 -> ack[0] 3 cycles after grant (LATENCY=2); rsp_g1=rsp_g2=10'h3FF (all-ones seeds); rsp_err=0; rsp_ch=0.
- req[1] with phase 1022 -> rsp_g1/g2 equal converter output for 1022; check against converter model; conv_phase=1022 throughout WAIT.
- req[0..3] all asserted, held and re-raised -> ack order 0,1,2,3,0,1..., one ack per 4 cycles, never two ack bits high.
- req[2] phase 1023 -> ack[2] one cycle after grant; rsp_err=1; rsp_g1=rsp_g2=10'h3FF; conv_phase unchanged.
- Assert rst=0 during WAIT for ch3 -> outputs return to reset values immediately; no ack[3]; after release a re-request completes normally.
- With LFSR_ARB_CACHE_EN: phase 500 twice on ch0 -> second ack at grant+1 with identical g1/g2. Then phase 501 -> full LATENCY+1 path.
